// File: rtl/lfsr_gen.sv
// Parameterised Fibonacci/Galois LFSR with free-run, seed load and counted bursts.
// All-zero states are replaced by SEED on advance so the generator cannot lock up.
module lfsr_gen #(
    parameter int unsigned       WIDTH  = 8,
    parameter logic [WIDTH-1:0]  TAPS   = WIDTH'(8'hD2),
    parameter logic [WIDTH-1:0]  SEED   = WIDTH'(8'h8A),
    parameter int unsigned       GALOIS = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             burst_start,
    input  logic [15:0]      burst_len,
    output logic [WIDTH-1:0] data,
    output logic             busy,
    output logic             done,
    output logic             lockup,
    output logic             wrap
);

    localparam int unsigned CNT_W = 16;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [0:0]       ctrl_q,   ctrl_d;
    logic [WIDTH-1:0] state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             done_q,   done_d;
    logic             lockup_q, lockup_d;
    logic             wrap_q,   wrap_d;

    logic [WIDTH-1:0] step_c;
    logic             adv_c;

    // Single-step successor of the current state, in the selected form.
    always_comb begin
        step_c = '0;
        if (GALOIS != 0) begin
            step_c[0] = state_q[WIDTH-1];
            for (int i = 1; i < int'(WIDTH); i++) begin
                step_c[i] = state_q[i-1] ^ (TAPS[i] & state_q[WIDTH-1]);
            end
        end else begin
            step_c = {state_q[WIDTH-2:0], ^(state_q & TAPS)};
        end
    end

    // Controller: load has top priority, then burst stepping, then burst acceptance, then en.
    always_comb begin
        ctrl_d   = ctrl_q;
        state_d  = state_q;
        cnt_d    = cnt_q;
        done_d   = 1'b0;
        lockup_d = 1'b0;
        wrap_d   = 1'b0;
        adv_c    = 1'b0;

        if (load) begin
            ctrl_d = ST_IDLE;
            cnt_d  = '0;
            if (load_data == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = load_data;
            end
        end else begin
            case (ctrl_q)
                ST_BURST: begin
                    adv_c = 1'b1;
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        ctrl_d = ST_IDLE;
                        done_d = 1'b1;
                    end
                end
                default: begin
                    if (burst_start && (burst_len != '0)) begin
                        cnt_d  = burst_len;
                        ctrl_d = ST_BURST;
                    end else if (en) begin
                        adv_c = 1'b1;
                    end
                end
            endcase
        end

        if (adv_c) begin
            if (state_q == '0) begin
                state_d  = SEED;
                lockup_d = 1'b1;
            end else begin
                state_d = step_c;
            end
            wrap_d = (state_d == SEED);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q   <= ST_IDLE;
            state_q  <= SEED;
            cnt_q    <= '0;
            done_q   <= 1'b0;
            lockup_q <= 1'b0;
            wrap_q   <= 1'b0;
        end else begin
            ctrl_q   <= ctrl_d;
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            done_q   <= done_d;
            lockup_q <= lockup_d;
            wrap_q   <= wrap_d;
        end
    end

    assign data   = state_q;
    assign busy   = (ctrl_q == ST_BURST);
    assign done   = done_q;
    assign lockup = lockup_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default Fibonacci instance plus a Galois instance.
module tb_lfsr_gen;

    logic        clk = 1'b0;
    logic        reset;
    logic        en, load, burst_start;
    logic [7:0]  load_data;
    logic [15:0] burst_len;
    logic [7:0]  data;
    logic        busy, done, lockup, wrap;

    logic        en_g;
    logic [7:0]  data_g;
    logic        busy_g, done_g, lockup_g, wrap_g;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lfsr_gen u_dut (
        .clk(clk), .reset(reset), .en(en), .load(load), .load_data(load_data),
        .burst_start(burst_start), .burst_len(burst_len),
        .data(data), .busy(busy), .done(done), .lockup(lockup), .wrap(wrap)
    );

    lfsr_gen #(.GALOIS(1)) u_gal (
        .clk(clk), .reset(reset), .en(en_g), .load(1'b0), .load_data(8'h00),
        .burst_start(1'b0), .burst_len(16'd0),
        .data(data_g), .busy(busy_g), .done(done_g), .lockup(lockup_g), .wrap(wrap_g)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Independent bitwise model of the default Fibonacci step (taps 7,6,4,1).
    function automatic logic [7:0] fib_ref(input logic [7:0] s);
        logic fb;
        fb = s[7] ^ s[6] ^ s[4] ^ s[1];
        return {s[6:0], fb};
    endfunction

    initial begin
        int period;
        int n;
        logic [7:0] s;
        logic seen;

        reset = 1'b0; en = 1'b0; load = 1'b0; burst_start = 1'b0;
        load_data = 8'h00; burst_len = 16'd0; en_g = 1'b0;

        #12;
        chk("rst_data", 32'(data), 32'h8A);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_flags", 32'({done, lockup, wrap}), 0);
        chk("rst_gal", 32'(data_g), 32'h8A);

        // Free run from SEED; Galois steps once.
        @(negedge clk);
        reset = 1'b1; en = 1'b1; en_g = 1'b1;
        step();
        en_g = 1'b0;
        chk("fr_0", 32'(data), 32'h14);
        chk("gal_0", 32'(data_g), 32'hC7);
        step(); chk("fr_1", 32'(data), 32'h29);
        step(); chk("fr_2", 32'(data), 32'h52);
        step(); chk("gal_hold", 32'(data_g), 32'hC7);

        // Back to SEED, then a 3-step burst with en low.
        en = 1'b0; load = 1'b1; load_data = 8'h8A;
        step(); load = 1'b0;
        chk("ld_seed", 32'(data), 32'h8A);
        chk("ld_nowrap", 32'(wrap), 0);
        burst_start = 1'b1; burst_len = 16'd3;
        step(); burst_start = 1'b0;
        chk("b_acc", 32'({busy, data}), 32'h18A);
        step(); chk("b_1", 32'({busy, done, data}), 32'h214);
        step(); chk("b_2", 32'({busy, done, data}), 32'h229);
        step(); chk("b_3", 32'({busy, done, data}), 32'h152);
        step(); chk("b_hold", 32'({busy, done, data}), 32'h052);

        // Zero load substitutes SEED and flags lockup.
        load = 1'b1; load_data = 8'h00;
        step(); load = 1'b0;
        chk("lz_data", 32'(data), 32'h8A);
        chk("lz_lock", 32'({lockup, wrap}), 32'h2);
        step(); chk("lz_pulse", 32'(lockup), 0);

        // Load during a burst aborts it without done.
        burst_start = 1'b1; burst_len = 16'd5;
        step(); burst_start = 1'b0;
        step(); chk("ab_mid", 32'({busy, data}), 32'h114);
        load = 1'b1; load_data = 8'h3C;
        step(); load = 1'b0;
        chk("ab_load", 32'({busy, done, data}), 32'h03C);
        step(); chk("ab_nodone", 32'({busy, done, data}), 32'h03C);

        // Period from the reference model vs wrap interval on the DUT.
        s = 8'h8A; period = 0;
        do begin s = fib_ref(s); period++; end while (s != 8'h8A && period < 1000);
        load = 1'b1; load_data = 8'h8A;
        step(); load = 1'b0; en = 1'b1;
        seen = 1'b0; n = 0;
        while (!seen && n < 600) begin
            step(); n++;
            if (wrap) seen = 1'b1;
        end
        chk("wrap_seen", 32'(seen), 1);
        chk("wrap_period", 32'(n), 32'(period));
        chk("wrap_data", 32'(data), 32'h8A);
        step(); chk("wrap_pulse", 32'(wrap), 0);
        en = 1'b0;

        // Reset pulse mid-burst discards it.
        burst_start = 1'b1; burst_len = 16'd100;
        step(); burst_start = 1'b0;
        step(); step();
        chk("rb_busy", 32'(busy), 1);
        reset = 1'b0;
        #1;
        chk("rb_async", 32'({busy, done, data}), 32'h08A);
        step();
        reset = 1'b1;
        step(); chk("rb_after", 32'({busy, done, data}), 32'h08A);

        // Zero-length burst strobe is ignored.
        burst_start = 1'b1; burst_len = 16'd0;
        step(); burst_start = 1'b0;
        chk("z_len", 32'({busy, done, data}), 32'h08A);
        step(); chk("z_len2", 32'({busy, done, data}), 32'h08A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
